// File: rtl/muldiv_engine.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and signed restoring divide.
// One iteration per cycle; results land in hi/lo 33 edges after start is taken.
module muldiv_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] m_q;       // multiplicand, or divisor magnitude
  logic [31:0] acc_q;     // Booth accumulator, or partial remainder
  logic [31:0] mq_q;      // multiplier, or dividend/quotient shift register
  logic        q1_q;
  logic [5:0]  cnt_q;
  logic        op_q, qneg_q, rneg_q, dz_q, done_q;
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic [32:0] booth_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ok;
  logic [31:0] a_mag, b_mag;
  logic [31:0] quot_fix, rem_fix;

  assign accept = start && !done_q;
  assign a_mag  = a_in[31] ? (~a_in + 32'd1) : a_in;
  assign b_mag  = b_in[31] ? (~b_in + 32'd1) : b_in;

  // 33-bit sum keeps the true sign so a multiplicand of 0x80000000 cannot overflow
  always_comb begin
    booth_sum = {acc_q[31], acc_q};
    case ({mq_q[0], q1_q})
      2'b01:   booth_sum = {acc_q[31], acc_q} + {m_q[31], m_q};
      2'b10:   booth_sum = {acc_q[31], acc_q} - {m_q[31], m_q};
      default: booth_sum = {acc_q[31], acc_q};
    endcase
  end

  // A set bit 32 in the shifted remainder always exceeds the divisor
  assign div_shift = {acc_q, mq_q[31]};
  assign div_ok    = div_shift[32] || (div_shift[31:0] >= m_q);
  assign div_diff  = div_shift[31:0] - m_q;

  assign quot_fix = qneg_q ? (~mq_q + 32'd1) : mq_q;
  assign rem_fix  = rneg_q ? (~acc_q + 32'd1) : acc_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = op ? DIV : MULT;
      MULT: if (cnt_q == 6'd31) state_d = DONE;
      DIV:  if (dz_q || cnt_q == 6'd31) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q    <= '0;
      acc_q  <= '0;
      mq_q   <= '0;
      q1_q   <= 1'b0;
      cnt_q  <= '0;
      op_q   <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          op_q   <= op;
          cnt_q  <= '0;
          acc_q  <= '0;
          q1_q   <= 1'b0;
          dz_q   <= op && (b_in == '0);
          qneg_q <= a_in[31] ^ b_in[31];
          rneg_q <= a_in[31];
          m_q    <= op ? b_mag : a_in;
          mq_q   <= op ? a_mag : b_in;
        end
        MULT: begin
          acc_q <= booth_sum[32:1];
          mq_q  <= {booth_sum[0], mq_q[31:1]};
          q1_q  <= mq_q[0];
          cnt_q <= cnt_q + 6'd1;
        end
        DIV: if (!dz_q) begin
          acc_q <= div_ok ? div_diff : div_shift[31:0];
          mq_q  <= {mq_q[30:0], div_ok};
          cnt_q <= cnt_q + 6'd1;
        end
        DONE: begin
          dz_q <= 1'b0;
          if (!dz_q) begin
            done_q <= 1'b1;
            hi_q   <= op_q ? rem_fix  : acc_q;
            lo_q   <= op_q ? quot_fix : mq_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Divide-by-zero reports from inside DONE; normal completion reports after it
  always_comb begin
    busy     = (state_q != IDLE) && !(state_q == DONE && dz_q);
    div_zero = (state_q == DONE) && dz_q;
    done     = done_q || div_zero;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: tb/tb_muldiv_engine.sv
// Directed self-checking bench for muldiv_engine: hand-computed results,
// cycle-exact done/busy timing, divide-by-zero, ignored starts and reset abort.
module tb_muldiv_engine;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a_in, b_in;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] prev_hi, prev_lo;

  muldiv_engine dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // flags = {busy, done, div_zero}
  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit restart_in_done);
    op = o; a_in = a; b_in = b; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    chk({tag, ".flags_E0"}, {29'd0, busy, done, div_zero}, 32'b100);
    for (int e = 1; e <= 32; e++) begin
      tick();
      chk({tag, ".flags_iter"}, {29'd0, busy, done, div_zero}, 32'b100);
      if (e == 16) begin
        chk({tag, ".hi_held"}, hi, prev_hi);
        chk({tag, ".lo_held"}, lo, prev_lo);
      end
    end
    tick();                                   // E33
    chk({tag, ".flags_E33"}, {29'd0, busy, done, div_zero}, 32'b010);
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
    if (restart_in_done) begin
      op = 1'b0; a_in = 32'd9; b_in = 32'd9; start = 1'b1;
    end
    tick();                                   // E34
    start = 1'b0;
    chk({tag, ".flags_E34"}, {29'd0, busy, done, div_zero}, 32'b000);
    if (restart_in_done) begin
      repeat (3) tick();
      chk({tag, ".ignored_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, ".ignored_hi"}, hi, eh);
      chk({tag, ".ignored_lo"}, lo, el);
    end
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (3) tick();
    chk("reset.flags", {29'd0, busy, done, div_zero}, 32'b000);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    // reset wins over start
    start = 1'b1; a_in = 32'd2; b_in = 32'd3;
    tick();
    start = 1'b0;
    chk("reset_prio.busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk("reset_rel.busy", {31'd0, busy}, 32'd0);
    prev_hi = '0; prev_lo = '0;

    run_op("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    run_op("mul_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("mul_minneg", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    // 0x451 = 0x22 * 0x20 + 0x11
    run_op("div_setup", 1'b1, 32'h0000_0451, 32'h20, 32'h11, 32'h22, 1'b0);

    // divide by zero: flags in the cycle after E1, results untouched
    op = 1'b1; a_in = 32'd5; b_in = 32'd0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    chk("dz.flags_E0", {29'd0, busy, done, div_zero}, 32'b100);
    tick();                                   // E1
    chk("dz.flags_E1", {29'd0, busy, done, div_zero}, 32'b011);
    chk("dz.hi_E1", hi, 32'h11);
    chk("dz.lo_E1", lo, 32'h22);
    tick();
    chk("dz.flags_E2", {29'd0, busy, done, div_zero}, 32'b000);
    repeat (35) tick();
    chk("dz.flags_late", {29'd0, busy, done, div_zero}, 32'b000);
    chk("dz.hi_late", hi, 32'h11);
    chk("dz.lo_late", lo, 32'h22);

    run_op("div_wrap", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // mid-operation re-start ignored, then reset aborts
    op = 1'b0; a_in = 32'd5; b_in = 32'd6; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    repeat (9) tick();                        // E9
    op = 1'b1; a_in = 32'd100; b_in = 32'd0; start = 1'b1;
    tick();                                   // E10
    start = 1'b0;
    chk("abort.flags_E10", {29'd0, busy, done, div_zero}, 32'b100);
    repeat (9) tick();                        // E19
    chk("abort.flags_E19", {29'd0, busy, done, div_zero}, 32'b100);
    chk("abort.hi_E19", hi, 32'h0);
    chk("abort.lo_E19", lo, 32'h8000_0000);
    reset = 1'b1;
    tick();                                   // E20
    reset = 1'b0;
    chk("abort.flags_E20", {29'd0, busy, done, div_zero}, 32'b000);
    chk("abort.hi_E20", hi, 32'h0);
    chk("abort.lo_E20", lo, 32'h0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("abort.no_done", {29'd0, busy, done, div_zero}, 32'b000);
    end
    prev_hi = '0; prev_lo = '0;
    run_op("mul_3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
